// File: rtl/theremin_freq_counter.sv
//------------------------------------------------------------------------------
// Module      : theremin_freq_counter
// Description : Gated oscillator edge counter with window averaging and a
//               sticky ready/overflow handshake toward a PIO input port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module theremin_freq_counter #(
  parameter int GATE_CYCLES = 500000,
  parameter int COUNT_W     = 16,
  parameter int AVG_LOG2    = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               osc_in,
  input  logic               read_ack,
  output logic [COUNT_W-1:0] freq_count,
  output logic               freq_valid,
  output logic               freq_ready,
  output logic               overflow,
  output logic               gate_active
);

  localparam int c_TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int c_IDX_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int c_ACC_W   = COUNT_W + AVG_LOG2;

  localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(GATE_CYCLES - 1);
  localparam logic [c_IDX_W-1:0]   c_IDX_LAST   = c_IDX_W'((1 << AVG_LOG2) - 1);
  localparam logic [COUNT_W-1:0]   c_CNT_MAX    = '1;

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_COUNT = 1'b1;

  logic                 r_s1, r_s2, r_s3;
  logic [0:0]           r_state;
  logic [c_TIMER_W-1:0] r_timer;
  logic [COUNT_W-1:0]   r_edge_cnt;
  logic [c_IDX_W-1:0]   r_win_idx;
  logic [c_ACC_W-1:0]   r_acc;
  logic                 r_grp_ovf;
  logic [COUNT_W-1:0]   r_freq_count;
  logic                 r_freq_valid;
  logic                 r_freq_ready;
  logic                 r_overflow;

  logic                 w_rise;
  logic                 w_sat;
  logic [COUNT_W-1:0]   w_win_sum;
  logic                 w_grp_ovf;
  logic                 w_timer_last;
  logic                 w_idx_last;
  logic [c_ACC_W-1:0]   w_grp_sum;
  logic [COUNT_W-1:0]   w_result;
  logic                 w_update;

  // s1 is the metastability catcher; the edge is detected between s2 and s3
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= osc_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_rise       = r_s2 & ~r_s3;
  assign w_sat        = w_rise && (r_edge_cnt == c_CNT_MAX);
  assign w_win_sum    = w_sat ? r_edge_cnt : (r_edge_cnt + COUNT_W'(w_rise));
  assign w_grp_ovf    = r_grp_ovf | w_sat;
  assign w_timer_last = (r_timer == c_TIMER_LAST);
  assign w_idx_last   = (r_win_idx == c_IDX_LAST);
  assign w_grp_sum    = r_acc + c_ACC_W'(w_win_sum);
  assign w_result     = COUNT_W'(w_grp_sum >> AVG_LOG2);
  assign w_update     = (r_state == c_ST_COUNT) && enable && w_timer_last && w_idx_last;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= c_ST_IDLE;
      r_timer      <= '0;
      r_edge_cnt   <= '0;
      r_win_idx    <= '0;
      r_acc        <= '0;
      r_grp_ovf    <= 1'b0;
      r_freq_count <= '0;
      r_freq_valid <= 1'b0;
    end else begin
      r_freq_valid <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          r_timer    <= '0;
          r_edge_cnt <= '0;
          r_win_idx  <= '0;
          r_acc      <= '0;
          r_grp_ovf  <= 1'b0;
          if (enable) begin
            r_state <= c_ST_COUNT;
          end
        end
        c_ST_COUNT: begin
          if (!enable) begin
            // abort discards the partial window and group; the result is kept
            r_state    <= c_ST_IDLE;
            r_timer    <= '0;
            r_edge_cnt <= '0;
            r_win_idx  <= '0;
            r_acc      <= '0;
            r_grp_ovf  <= 1'b0;
          end else if (w_timer_last) begin
            r_timer    <= '0;
            r_edge_cnt <= '0;
            if (w_idx_last) begin
              r_acc        <= '0;
              r_win_idx    <= '0;
              r_grp_ovf    <= 1'b0;
              r_freq_count <= w_result;
              r_freq_valid <= 1'b1;
            end else begin
              r_acc     <= w_grp_sum;
              r_win_idx <= r_win_idx + c_IDX_W'(1);
              r_grp_ovf <= w_grp_ovf;
            end
          end else begin
            r_timer    <= r_timer + c_TIMER_W'(1);
            r_edge_cnt <= w_win_sum;
            r_grp_ovf  <= w_grp_ovf;
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
        end
      endcase
    end
  end

  // A new result takes priority over an acknowledge in the same cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_freq_ready <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (w_update) begin
      r_freq_ready <= 1'b1;
      r_overflow   <= w_grp_ovf;
    end else if (read_ack) begin
      r_freq_ready <= 1'b0;
      r_overflow   <= 1'b0;
    end
  end

  assign freq_count  = r_freq_count;
  assign freq_valid  = r_freq_valid;
  assign freq_ready  = r_freq_ready;
  assign overflow    = r_overflow;
  assign gate_active = (r_state == c_ST_COUNT);

endmodule

`default_nettype wire

// File: tb/tb_theremin_freq_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_theremin_freq_counter
// Description : Directed self-checking bench for theremin_freq_counter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_theremin_freq_counter;

  localparam int GATE_CYCLES = 100;
  localparam int COUNT_W     = 5;
  localparam int AVG_LOG2    = 2;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               enable;
  logic               read_ack;
  logic               osc_manual;
  logic               osc_gen;
  logic               osc_in;
  logic [COUNT_W-1:0] freq_count;
  logic               freq_valid;
  logic               freq_ready;
  logic               overflow;
  logic               gate_active;

  int osc_period = 0;
  int osc_phase  = 0;
  int errors     = 0;
  int checks     = 0;
  int win_tab [8] = '{9, 10, 10, 10, 8, 12, 8, 12};

  theremin_freq_counter #(
    .GATE_CYCLES(GATE_CYCLES),
    .COUNT_W    (COUNT_W),
    .AVG_LOG2   (AVG_LOG2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .osc_in     (osc_in),
    .read_ack   (read_ack),
    .freq_count (freq_count),
    .freq_valid (freq_valid),
    .freq_ready (freq_ready),
    .overflow   (overflow),
    .gate_active(gate_active)
  );

  always #5 clk = ~clk;

  // Free-running square wave: low for the first half-period, then high
  always @(negedge clk) begin
    if (osc_period == 0) begin
      osc_phase <= 0;
      osc_gen   <= 1'b0;
    end else begin
      osc_gen   <= (osc_phase >= osc_period / 2);
      osc_phase <= (osc_phase >= osc_period - 1) ? 0 : osc_phase + 1;
    end
  end

  assign osc_in = (osc_period != 0) ? osc_gen : osc_manual;

  // Pin level at gate cycle k: win_tab[k/100] pulses of 2 high / 2 low from offset 10
  function automatic logic wave(input int k);
    int w;
    int o;
    if (k < 0 || k >= 800) return 1'b0;
    w = k / 100;
    o = k % 100;
    return (o >= 10) && (o < 10 + 4 * win_tab[w]) && (((o - 10) % 4) < 2);
  endfunction

  // Edges counted from the next clk up to and including the freq_valid edge
  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (freq_valid !== 1'b1 && n <= limit);
  endtask

  task automatic test_reset;
    reset_n    = 1'b0;
    enable     = 1'b1;
    read_ack   = 1'b0;
    osc_manual = 1'b0;
    osc_period = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({freq_count, freq_valid, freq_ready, overflow, gate_active} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, want 000000000",
               {freq_count, freq_valid, freq_ready, overflow, gate_active});
    end
  endtask

  task automatic test_steady;
    int n;
    reset_n    = 1'b1;
    osc_period = 10;
    wait_valid(600, n);
    checks++;
    if (n !== 401) begin errors++; $display("FAIL first_latency: got %0d, want 401", n); end
    checks++;
    if (freq_count !== 5'd10) begin errors++; $display("FAIL steady_count: got %0d, want 10", freq_count); end
    checks++;
    if (freq_ready !== 1'b1 || overflow !== 1'b0 || gate_active !== 1'b1) begin
      errors++;
      $display("FAIL steady_flags: got rdy=%b ovf=%b gate=%b, want 1 0 1", freq_ready, overflow, gate_active);
    end
    @(posedge clk);
    #1;
    checks++;
    if (freq_valid !== 1'b0) begin errors++; $display("FAIL valid_width: got %b, want 0", freq_valid); end
    wait_valid(600, n);
    checks++;
    if (n !== 399) begin errors++; $display("FAIL valid_period: got %0d, want 399", n); end
    checks++;
    if (freq_count !== 5'd10 || freq_ready !== 1'b1) begin
      errors++;
      $display("FAIL overwrite: got cnt=%0d rdy=%b, want 10 1", freq_count, freq_ready);
    end
  endtask

  task automatic test_abort;
    int n;
    int pulses;
    repeat (150) @(posedge clk);
    #1;
    enable = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (gate_active !== 1'b0) begin errors++; $display("FAIL abort_gate: got %b, want 0", gate_active); end
    pulses = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      if (freq_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses, want 0", pulses); end
    checks++;
    if (freq_count !== 5'd10 || freq_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_hold: got cnt=%0d rdy=%b, want 10 1", freq_count, freq_ready);
    end
    enable = 1'b1;
    wait_valid(600, n);
    checks++;
    if (n !== 401) begin errors++; $display("FAIL reenable_latency: got %0d, want 401", n); end
  endtask

  task automatic test_ack_collision;
    read_ack = 1'b1;
    @(posedge clk);
    #1;
    read_ack = 1'b0;
    checks++;
    if (freq_ready !== 1'b0) begin errors++; $display("FAIL ack_clear: got %b, want 0", freq_ready); end
    repeat (398) @(posedge clk);
    #1;
    read_ack = 1'b1;
    @(posedge clk);
    #1;
    read_ack = 1'b0;
    checks++;
    if (freq_valid !== 1'b1 || freq_ready !== 1'b1) begin
      errors++;
      $display("FAIL ack_collide: got vld=%b rdy=%b, want 1 1", freq_valid, freq_ready);
    end
    repeat (4) @(posedge clk);
    #1;
    read_ack = 1'b1;
    @(posedge clk);
    #1;
    read_ack = 1'b0;
    checks++;
    if (freq_ready !== 1'b0) begin errors++; $display("FAIL ack_late: got %b, want 0", freq_ready); end
  endtask

  task automatic test_reset_mid;
    int n;
    wait_valid(600, n);
    checks++;
    if (freq_count !== 5'd10 || freq_ready !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got cnt=%0d rdy=%b, want 10 1", freq_count, freq_ready);
    end
    repeat (50) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({freq_count, freq_valid, freq_ready, overflow, gate_active} !== 9'd0) begin
      errors++;
      $display("FAIL mid_reset: got %b, want 000000000",
               {freq_count, freq_valid, freq_ready, overflow, gate_active});
    end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_valid(600, n);
    checks++;
    if (n !== 401 || freq_count !== 5'd10) begin
      errors++;
      $display("FAIL post_reset: got lat=%0d cnt=%0d, want 401 10", n, freq_count);
    end
  endtask

  task automatic test_back_to_back;
    int stray;
    osc_period = 0;
    osc_manual = 1'b0;
    enable     = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    stray = 0;
    for (int k = 0; k < 800; k++) begin
      osc_manual = wave(k);
      @(posedge clk);
      #1;
      if (k == 399) begin
        checks++;
        if (freq_valid !== 1'b1 || freq_count !== 5'd9) begin
          errors++;
          $display("FAIL avg_truncate: got vld=%b cnt=%0d, want 1 9", freq_valid, freq_count);
        end
      end else if (k == 799) begin
        checks++;
        if (freq_valid !== 1'b1 || freq_count !== 5'd10 || overflow !== 1'b0) begin
          errors++;
          $display("FAIL avg_mixed: got vld=%b cnt=%0d ovf=%b, want 1 10 0", freq_valid, freq_count, overflow);
        end
      end else if (freq_valid === 1'b1) begin
        stray++;
      end
    end
    checks++;
    if (stray !== 0) begin errors++; $display("FAIL stray_valid: got %0d, want 0", stray); end
  endtask

  task automatic test_saturate;
    int n;
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    osc_period = 2;
    enable     = 1'b1;
    wait_valid(600, n);
    checks++;
    if (n !== 401 || freq_count !== 5'd31) begin
      errors++;
      $display("FAIL sat_count: got lat=%0d cnt=%0d, want 401 31", n, freq_count);
    end
    checks++;
    if (overflow !== 1'b1 || freq_ready !== 1'b1) begin
      errors++;
      $display("FAIL sat_flags: got ovf=%b rdy=%b, want 1 1", overflow, freq_ready);
    end
    read_ack = 1'b1;
    @(posedge clk);
    #1;
    read_ack = 1'b0;
    checks++;
    if (overflow !== 1'b0 || freq_ready !== 1'b0) begin
      errors++;
      $display("FAIL sat_ack: got ovf=%b rdy=%b, want 0 0", overflow, freq_ready);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_abort();
    test_ack_collision();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
